dw01_satrnd_expand: RTL and testbench
=====================================

// Module: dw01_satrnd_expand
// PURPOSE
//  Streaming re-expander for the narrow words a saturate/round stage produces.
//  - Takes dout-format words, (msb_out-lsb_out+1) bits each, plus their ov flag.
//  - Rebuilds each word at full width-bit scale: shift left by lsb_out, extend above msb_out.
//  - Registered valid/ready pipeline with a 2-entry skid; full throughput.
//  - Keeps a saturating overflow-event counter and a sticky overflow flag.
// PARAMETERS
//  width      8   full-scale data width; >= 2
//  msb_out    7   MSB position of narrow word in full scale; lsb_out <= msb_out <= width-1
//  lsb_out    1   LSB position of narrow word in full scale; >= 0
//  cnt_width  16  overflow counter width; >= 1
// PORTS
//  clk        in   1                  clock, rising edge
//  rst_n      in   1                  async active-low reset
//  s_valid    in   1                  input word valid
//  s_ready    out  1                  input can accept
//  s_data     in   msb_out-lsb_out+1  narrow word
//  s_ov       in   1                  word was saturated upstream
//  s_tc       in   1                  1 = two's complement, 0 = unsigned (per word)
//  fill_half  in   1                  1 = set bit lsb_out-1 on reconstruct (bias centring)
//  m_valid    out  1                  output word valid
//  m_ready    in   1                  downstream accepts
//  m_data     out  width              reconstructed full-scale word
//  m_ov       out  1                  ov flag travelling with m_data
//  clr_cnt    in   1                  sync clear of ov_count and ov_sticky
//  ov_count   out  cnt_width          accepted words with s_ov=1, saturating
//  ov_sticky  out  1                  set on any accepted s_ov=1 word
// BEHAVIOUR
//  Reset values: m_valid=0, s_ready=1, m_data=0, m_ov=0, ov_count=0, ov_sticky=0. Skid is empty.
//  Acceptance and transfer:
//  - Input accepted when s_valid&s_ready; output transferred when m_valid&m_ready.
//  - Latency: accepted word appears on m_data on the next cycle, when the output register is free.
//  Output register (O) and skid register (K):
//  - Accept, O empty or transferring -> word goes to O.
//  - Accept, O held (m_valid & ~m_ready) -> word goes to K.
//  - O transfers while K full -> K moves to O and K empties.
//  - s_ready = ~K_full, registered. Never combinational from m_ready.
//  - Sustained 1 word/cycle while m_ready=1.
//  - m_data, m_ov stable while m_valid & ~m_ready.
//  Reconstruction, computed at accept and stored with s_ov:
//  - m_data[msb_out:lsb_out] = s_data.
//  - Bits width-1:msb_out+1 = s_data MSB if s_tc=1, else 0. Absent when msb_out = width-1.
//  - Bits lsb_out-1:0 = 0, except bit lsb_out-1 = fill_half. Absent when lsb_out = 0.
//  - s_tc and fill_half are sampled at accept only; later changes do not alter stored words.
//  Overflow counter:
//  - Increments on accepted s_ov=1 and holds at 2^cnt_width-1; never wraps.
//  - clr_cnt alone -> ov_count=0, ov_sticky=0.
//  - clr_cnt with an accepted s_ov=1 in the same cycle -> ov_count=1, ov_sticky=1.
//  - Counts are at accept, not at output transfer.
//  Reset mid-operation: both entries are discarded immediately (async) and outputs return to reset values.
// STRUCTURE
//  Package dw01_satrnd_pkg:
//  - localparam function nbits(msb_out,lsb_out).
//  - Function expand(data, tc, fill_half) returning width bits.
//  Sub-module dw01_skid_buf: generic 2-entry valid/ready skid, parameter DW for the payload.
//  - Payload here is {ov, width-bit data}.
//  Top-level logic: expand function at the input, counter/sticky logic, skid instance.
// TESTING (defaults width=8, msb_out=7, lsb_out=1 unless stated)
//  1. s_data=7'h41, s_tc=1, fill_half=0, m_ready=1 -> next cycle m_data=8'h82, m_ov=0.
//     With fill_half=1 and s_data=7'h7F -> m_data=8'hFF.
//  2. Override width=12, msb_out=7, lsb_out=1, s_data=7'h40:
//     s_tc=1 -> m_data=12'hF80; s_tc=0 -> m_data=12'h080.
//  3. Back-pressure: stream 0x01,0x02,0x03 with m_ready=0 for 3 cycles.
//     -> s_ready drops after the 2nd accept; m_data holds 0x02.
//     -> on release the order is 0x02,0x04,0x06 and no word is lost or duplicated.
//  4. Overflow counter, cnt_width=2: 5 accepted s_ov=1 words.
//     -> ov_count=3, held; ov_sticky=1.
//     Then clr_cnt together with an accepted s_ov=1 -> ov_count=1.
//  5. Random valid/ready traffic for 10k words vs a reference queue.
//     -> in-order, exact data and ov; throughput 1/cycle whenever m_ready=1.
//  6. Assert rst_n low with both entries full.
//     -> m_valid=0, s_ready=1, ov_count=0 immediately, without a clock edge.

Source files
------------

// File: rtl/dw01_satrnd_pkg.sv
// Shared helpers for the saturate/round re-expander: field sizing and
// reconstruction of a narrow word back onto the full-scale bit grid.
package dw01_satrnd_pkg;

    // Widest full-scale word the expand helper can build; callers truncate.
    localparam int unsigned MAX_W = 64;

    // Number of bits in the narrow field [msb:lsb].
    function automatic int unsigned nbits(input int unsigned msb, input int unsigned lsb);
        return msb - lsb + 1;
    endfunction

    // Place the narrow field at [msb:lsb], extend above msb (sign or zero),
    // and optionally set bit lsb-1 to centre the truncation bias.
    function automatic logic [MAX_W-1:0] expand(
        input logic [MAX_W-1:0] data,
        input int unsigned      msb,
        input int unsigned      lsb,
        input logic             tc,
        input logic             fill_half
    );
        logic [MAX_W-1:0] field;
        logic [MAX_W-1:0] result;
        logic             sign;
        int unsigned      n;
        n      = msb - lsb + 1;
        field  = data & ((MAX_W'(1) << n) - MAX_W'(1));
        sign   = |(field & (MAX_W'(1) << (n - 1)));
        result = field << lsb;
        if (tc && sign) begin
            result = result | ~((MAX_W'(1) << (msb + 1)) - MAX_W'(1));
        end
        if (fill_half && (lsb != 0)) begin
            result = result | (MAX_W'(1) << (lsb - 1));
        end
        return result;
    endfunction

endpackage

// File: rtl/dw01_satrnd_expand_if.sv
// Stream, control and status signals of the re-expander.
interface dw01_satrnd_expand_if
    import dw01_satrnd_pkg::*;
#(
    parameter int unsigned width     = 8,
    parameter int unsigned msb_out   = 7,
    parameter int unsigned lsb_out   = 1,
    parameter int unsigned cnt_width = 16
);
    localparam int unsigned NW = nbits(msb_out, lsb_out);

    logic                 s_valid;
    logic                 s_ready;
    logic [NW-1:0]        s_data;
    logic                 s_ov;
    logic                 s_tc;
    logic                 fill_half;
    logic                 m_valid;
    logic                 m_ready;
    logic [width-1:0]     m_data;
    logic                 m_ov;
    logic                 clr_cnt;
    logic [cnt_width-1:0] ov_count;
    logic                 ov_sticky;

    modport master (
        output s_valid, s_data, s_ov, s_tc, fill_half, m_ready, clr_cnt,
        input  s_ready, m_valid, m_data, m_ov, ov_count, ov_sticky
    );

    modport slave (
        input  s_valid, s_data, s_ov, s_tc, fill_half, m_ready, clr_cnt,
        output s_ready, m_valid, m_data, m_ov, ov_count, ov_sticky
    );

endinterface

// File: rtl/dw01_skid_buf.sv
// Generic 2-entry valid/ready skid: output register O plus skid register K.
// in_ready is a flop (never a combinational path from out_ready).
module dw01_skid_buf #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          o_valid_q, o_valid_d;
    logic [DW-1:0] o_data_q,  o_data_d;
    logic          k_full_q,  k_full_d;
    logic [DW-1:0] k_data_q,  k_data_d;
    logic          in_ready_q, in_ready_d;
    logic          accept_c;
    logic          o_free_c;

    // Next-state: refill O from K first, otherwise from the input; park in K when O is held.
    always_comb begin
        o_valid_d  = o_valid_q;
        o_data_d   = o_data_q;
        k_full_d   = k_full_q;
        k_data_d   = k_data_q;
        accept_c   = in_valid & in_ready_q;
        o_free_c   = ~o_valid_q | out_ready;
        if (o_free_c) begin
            if (k_full_q) begin
                o_data_d  = k_data_q;
                o_valid_d = 1'b1;
                k_full_d  = 1'b0;
            end else if (accept_c) begin
                o_data_d  = in_data;
                o_valid_d = 1'b1;
            end else begin
                o_valid_d = 1'b0;
            end
        end else if (accept_c) begin
            k_data_d = in_data;
            k_full_d = 1'b1;
        end
        in_ready_d = ~k_full_d;
    end

    // State registers; reset discards both entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
            k_full_q   <= 1'b0;
            k_data_q   <= '0;
            in_ready_q <= 1'b1;
        end else begin
            o_valid_q  <= o_valid_d;
            o_data_q   <= o_data_d;
            k_full_q   <= k_full_d;
            k_data_q   <= k_data_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = o_valid_q;
    assign out_data  = o_data_q;

endmodule

// File: rtl/dw01_satrnd_expand.sv
// Re-expands narrow saturate/round words to full scale through a skid
// pipeline, and tracks accepted overflow words in a saturating counter.
module dw01_satrnd_expand
    import dw01_satrnd_pkg::*;
#(
    parameter int unsigned width     = 8,
    parameter int unsigned msb_out   = 7,
    parameter int unsigned lsb_out   = 1,
    parameter int unsigned cnt_width = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dw01_satrnd_expand_if.slave    bus
);

    localparam int unsigned NW = nbits(msb_out, lsb_out);
    localparam int unsigned PW = width + 1;
    localparam logic [cnt_width-1:0] CNT_MAX = '1;

    logic                 accept_c;
    logic                 ov_accept_c;
    logic [width-1:0]     exp_data_c;
    logic [PW-1:0]        in_payload_c;
    logic [PW-1:0]        out_payload;
    logic [cnt_width-1:0] ov_count_q, ov_count_d;
    logic                 ov_sticky_q, ov_sticky_d;

    assign accept_c    = bus.s_valid & bus.s_ready;
    assign ov_accept_c = accept_c & bus.s_ov;

    // Reconstruction happens at accept so tc/fill_half are captured with the word.
    assign exp_data_c   = width'(expand(MAX_W'(bus.s_data), msb_out, lsb_out,
                                        bus.s_tc, bus.fill_half));
    assign in_payload_c = {bus.s_ov, exp_data_c};

    dw01_skid_buf #(
        .DW (PW)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.s_valid),
        .in_ready  (bus.s_ready),
        .in_data   (in_payload_c),
        .out_valid (bus.m_valid),
        .out_ready (bus.m_ready),
        .out_data  (out_payload)
    );

    assign bus.m_ov   = out_payload[width];
    assign bus.m_data = out_payload[width-1:0];

    // Counter next-state: clear wins over history, but a same-cycle overflow word still counts.
    always_comb begin
        ov_count_d  = ov_count_q;
        ov_sticky_d = ov_sticky_q;
        if (bus.clr_cnt) begin
            ov_count_d  = ov_accept_c ? cnt_width'(1) : '0;
            ov_sticky_d = ov_accept_c;
        end else if (ov_accept_c) begin
            ov_sticky_d = 1'b1;
            if (ov_count_q != CNT_MAX) begin
                ov_count_d = ov_count_q + cnt_width'(1);
            end
        end
    end

    // Counter and sticky registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_count_q  <= '0;
            ov_sticky_q <= 1'b0;
        end else begin
            ov_count_q  <= ov_count_d;
            ov_sticky_q <= ov_sticky_d;
        end
    end

    assign bus.ov_count  = ov_count_q;
    assign bus.ov_sticky = ov_sticky_q;

endmodule

// File: tb/tb_dw01_satrnd_expand.sv
// Directed and random checks of dw01_satrnd_expand in three configurations.
module tb_dw01_satrnd_expand;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_pass   = 0;

    // A: defaults, B: wide output with sign extension, C: lsb_out=0 and 2-bit counter.
    dw01_satrnd_expand_if #(.width(8),  .msb_out(7), .lsb_out(1), .cnt_width(16)) ifa ();
    dw01_satrnd_expand_if #(.width(12), .msb_out(7), .lsb_out(1), .cnt_width(16)) ifb ();
    dw01_satrnd_expand_if #(.width(8),  .msb_out(4), .lsb_out(0), .cnt_width(2))  ifc ();

    dw01_satrnd_expand #(.width(8),  .msb_out(7), .lsb_out(1), .cnt_width(16)) dut_a (
        .clk (clk), .rst_n (rst_n), .bus (ifa));
    dw01_satrnd_expand #(.width(12), .msb_out(7), .lsb_out(1), .cnt_width(16)) dut_b (
        .clk (clk), .rst_n (rst_n), .bus (ifb));
    dw01_satrnd_expand #(.width(8),  .msb_out(4), .lsb_out(0), .cnt_width(2))  dut_c (
        .clk (clk), .rst_n (rst_n), .bus (ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  d;
        logic        tc;
        logic        fh;
        logic        ov;
        logic [11:0] e;
    } vec_t;

    vec_t va [6];
    vec_t vb [4];
    vec_t vc [3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] got_q[$];
        logic [7:0] exp_q[$];
        logic       ovq[$];
        logic [7:0] w;
        logic       wov;
        logic       acc;
        int         sent, got, errs, ov_acc;

        // A: 7-bit field at [7:1]; no room above, so tc has no effect.
        va[0] = '{7'h41, 1'b1, 1'b0, 1'b0, 12'h082};
        va[1] = '{7'h7F, 1'b1, 1'b1, 1'b0, 12'h0FF};
        va[2] = '{7'h40, 1'b0, 1'b0, 1'b0, 12'h080};
        va[3] = '{7'h00, 1'b1, 1'b1, 1'b0, 12'h001};
        va[4] = '{7'h55, 1'b0, 1'b0, 1'b1, 12'h0AA};
        va[5] = '{7'h2A, 1'b1, 1'b1, 1'b0, 12'h055};
        // B: 12-bit output, bits 11:8 are extension.
        vb[0] = '{7'h40, 1'b1, 1'b0, 1'b0, 12'hF80};
        vb[1] = '{7'h40, 1'b0, 1'b0, 1'b0, 12'h080};
        vb[2] = '{7'h7F, 1'b1, 1'b1, 1'b1, 12'hFFF};
        vb[3] = '{7'h3F, 1'b1, 1'b1, 1'b0, 12'h07F};
        // C: 5-bit field at [4:0]; fill_half has no bit to set.
        vc[0] = '{7'h10, 1'b1, 1'b1, 1'b0, 12'h0F0};
        vc[1] = '{7'h0F, 1'b1, 1'b1, 1'b0, 12'h00F};
        vc[2] = '{7'h10, 1'b0, 1'b0, 1'b0, 12'h010};

        rst_n = 1'b0;
        ifa.s_valid = 0; ifa.s_data = '0; ifa.s_ov = 0; ifa.s_tc = 0; ifa.fill_half = 0;
        ifa.m_ready = 1; ifa.clr_cnt = 0;
        ifb.s_valid = 0; ifb.s_data = '0; ifb.s_ov = 0; ifb.s_tc = 0; ifb.fill_half = 0;
        ifb.m_ready = 1; ifb.clr_cnt = 0;
        ifc.s_valid = 0; ifc.s_data = '0; ifc.s_ov = 0; ifc.s_tc = 0; ifc.fill_half = 0;
        ifc.m_ready = 1; ifc.clr_cnt = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_m_valid", ifa.m_valid, 1'b0);
        check("rst_s_ready", ifa.s_ready, 1'b1);
        check("rst_m_data",  ifa.m_data, 8'h00);
        check("rst_m_ov",    ifa.m_ov, 1'b0);
        check("rst_count",   ifa.ov_count, 16'h0);
        check("rst_sticky",  ifa.ov_sticky, 1'b0);

        // Table vectors, one word per cycle with m_ready=1
        for (int i = 0; i < 6; i++) begin
            ifa.s_valid = 1; ifa.s_data = va[i].d; ifa.s_tc = va[i].tc;
            ifa.fill_half = va[i].fh; ifa.s_ov = va[i].ov;
            tick();
            ifa.s_valid = 0;
            check($sformatf("a%0d_valid", i), ifa.m_valid, 1'b1);
            check($sformatf("a%0d_data", i),  ifa.m_data, va[i].e[7:0]);
            check($sformatf("a%0d_ov", i),    ifa.m_ov, va[i].ov);
        end
        for (int i = 0; i < 4; i++) begin
            ifb.s_valid = 1; ifb.s_data = vb[i].d; ifb.s_tc = vb[i].tc;
            ifb.fill_half = vb[i].fh; ifb.s_ov = vb[i].ov;
            tick();
            ifb.s_valid = 0;
            check($sformatf("b%0d_data", i), ifb.m_data, vb[i].e);
            check($sformatf("b%0d_ov", i),   ifb.m_ov, vb[i].ov);
        end
        for (int i = 0; i < 3; i++) begin
            ifc.s_valid = 1; ifc.s_data = vc[i].d[4:0]; ifc.s_tc = vc[i].tc;
            ifc.fill_half = vc[i].fh; ifc.s_ov = vc[i].ov;
            tick();
            ifc.s_valid = 0;
            check($sformatf("c%0d_data", i), ifc.m_data, vc[i].e[7:0]);
        end
        tick();
        check("a_idle_valid", ifa.m_valid, 1'b0);

        // tc/fill_half changes after accept must not alter a held word
        ifb.m_ready = 0; ifb.s_valid = 1; ifb.s_data = 7'h40; ifb.s_tc = 1; ifb.fill_half = 0;
        tick();
        ifb.s_valid = 0; ifb.s_tc = 0; ifb.fill_half = 1;
        tick();
        tick();
        check("b_hold_data", ifb.m_data, 12'hF80);
        ifb.m_ready = 1;
        tick();

        // Back-pressure: 3 words, m_ready low for 3 cycles
        ifa.m_ready = 0; ifa.s_tc = 0; ifa.fill_half = 0; ifa.s_ov = 0;
        ifa.s_valid = 1; ifa.s_data = 7'h01;
        tick();
        check("bp1_s_ready", ifa.s_ready, 1'b1);
        check("bp1_m_data",  ifa.m_data, 8'h02);
        ifa.s_data = 7'h02;
        tick();
        check("bp2_s_ready", ifa.s_ready, 1'b0);
        check("bp2_m_data",  ifa.m_data, 8'h02);
        ifa.s_data = 7'h03;
        tick();
        check("bp3_s_ready", ifa.s_ready, 1'b0);
        check("bp3_m_data",  ifa.m_data, 8'h02);
        ifa.m_ready = 1;
        for (int c = 0; c < 6; c++) begin
            if (ifa.m_valid && ifa.m_ready) got_q.push_back(ifa.m_data);
            acc = ifa.s_valid & ifa.s_ready;
            tick();
            if (acc) ifa.s_valid = 0;
        end
        check("bp_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("bp_w0", got_q[0], 8'h02);
            check("bp_w1", got_q[1], 8'h04);
            check("bp_w2", got_q[2], 8'h06);
        end

        // Overflow counter saturation and clear on C
        ifc.clr_cnt = 1;
        tick();
        ifc.clr_cnt = 0;
        check("c_clr_count", ifc.ov_count, 2'd0);
        ifc.s_valid = 1; ifc.s_ov = 1; ifc.s_data = 5'h03;
        tick();
        check("c_ov1_count", ifc.ov_count, 2'd1);
        check("c_ov1_sticky", ifc.ov_sticky, 1'b1);
        repeat (4) tick();
        check("c_ov5_count", ifc.ov_count, 2'd3);
        check("c_ov5_sticky", ifc.ov_sticky, 1'b1);
        check("c_ov5_m_ov", ifc.m_ov, 1'b1);
        ifc.clr_cnt = 1;
        tick();
        check("c_clr_ov_count", ifc.ov_count, 2'd1);
        check("c_clr_ov_sticky", ifc.ov_sticky, 1'b1);
        ifc.s_valid = 0;
        tick();
        ifc.clr_cnt = 0;
        check("c_clr_only_count", ifc.ov_count, 2'd0);
        check("c_clr_only_sticky", ifc.ov_sticky, 1'b0);

        // Full throughput with m_ready held high
        for (int i = 0; i < 16; i++) begin
            ifa.s_valid = 1; ifa.s_ov = 0; ifa.s_data = 7'(i + 16);
            check($sformatf("tp%0d_s_ready", i), ifa.s_ready, 1'b1);
            if (i > 0) check($sformatf("tp%0d_data", i), ifa.m_data, 8'((i + 15) * 2));
            tick();
        end
        ifa.s_valid = 0;
        tick();

        // Random traffic against a reference queue
        ifa.clr_cnt = 1;
        tick();
        ifa.clr_cnt = 0;
        check("a_clr_count", ifa.ov_count, 16'h0);
        sent = 0; got = 0; errs = 0; ov_acc = 0;
        for (int cyc = 0; cyc < 60000 && got < 10000; cyc++) begin
            if (!ifa.s_valid && sent < 10000 && $urandom_range(0, 9) < 7) begin
                ifa.s_valid   = 1;
                ifa.s_data    = 7'($urandom);
                ifa.s_tc      = 1'($urandom);
                ifa.fill_half = 1'($urandom);
                ifa.s_ov      = 1'($urandom);
            end
            ifa.m_ready = ($urandom_range(0, 9) < 7);
            if (exp_q.size() > 0 && !ifa.m_valid) errs++;
            if (ifa.m_valid && ifa.m_ready) begin
                if (exp_q.size() == 0) errs++;
                else begin
                    w = exp_q.pop_front();
                    wov = ovq.pop_front();
                    if (ifa.m_data !== w || ifa.m_ov !== wov) errs++;
                end
                got++;
            end
            acc = ifa.s_valid & ifa.s_ready;
            if (acc) begin
                exp_q.push_back({ifa.s_data, ifa.fill_half});
                ovq.push_back(ifa.s_ov);
                if (ifa.s_ov) ov_acc++;
                sent++;
            end
            tick();
            if (acc) ifa.s_valid = 0;
        end
        check("rand_words", got, 10000);
        check("rand_errors", errs, 0);
        check("rand_count", ifa.ov_count, 16'(ov_acc));
        check("rand_sticky", ifa.ov_sticky, 1'(ov_acc > 0));

        // Async reset with both entries full
        ifa.m_ready = 0; ifa.s_ov = 1; ifa.s_valid = 1; ifa.s_data = 7'h11;
        tick();
        ifa.s_data = 7'h22;
        tick();
        ifa.s_valid = 0;
        check("full_s_ready", ifa.s_ready, 1'b0);
        check("full_m_valid", ifa.m_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_m_valid", ifa.m_valid, 1'b0);
        check("arst_s_ready", ifa.s_ready, 1'b1);
        check("arst_m_data",  ifa.m_data, 8'h00);
        check("arst_m_ov",    ifa.m_ov, 1'b0);
        check("arst_count",   ifa.ov_count, 16'h0);
        check("arst_sticky",  ifa.ov_sticky, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        ifa.m_ready = 1;
        tick();
        check("post_rst_m_valid", ifa.m_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
